// File: rtl/retire_chk_pkg.sv
// -----------------------------------------------------------------------------
// retire_chk_pkg
// Shared types and constants for the retire_checker shadow pipeline.
//   entry_t : one expected-retirement record as it travels down the pipe
//   state_t : halt/drain state machine encoding
//   REG_X0  : index of the hard-wired zero register
// Optional feature macro: CHECKER_PC_EN (adds the pc field to entry_t).
// -----------------------------------------------------------------------------
package retire_chk_pkg;

    // Width of the golden-result field. The top-level XLEN parameter must
    // match this value, because the record struct is sized from here.
    localparam int CHK_XLEN = 32;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [31:0]         inst;
        logic [4:0]          rd;
        logic                wr;
        logic [CHK_XLEN-1:0] expected;
`ifdef CHECKER_PC_EN
        logic [31:0]         pc;
`endif
    } entry_t;

endpackage

// File: rtl/retire_cmp.sv
// -----------------------------------------------------------------------------
// retire_cmp
// Purely combinational pass/fail decision for the record at the last stage
// against the core's register-file write port.
//   rd, wr, expected : destination, write flag and golden result of the record
//   wb_en, wb_rd,
//   wb_data          : core register-file write port at retirement
//   pass             : 1 when the core's write agrees with the record
// -----------------------------------------------------------------------------
module retire_cmp
    import retire_chk_pkg::*;
#(
    parameter int XLEN = CHK_XLEN
) (
    input  logic [4:0]      rd,
    input  logic            wr,
    input  logic [XLEN-1:0] expected,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            pass
);

    always_comb begin
        pass = 1'b0;
        if (wr && (rd != REG_X0)) begin
            // A real write must hit the right register with the right value.
            pass = wb_en && (wb_rd == rd) && (wb_data == expected);
        end else begin
            // No architectural write expected; a write to x0 is harmless.
            pass = !wb_en || (wb_rd == REG_X0);
        end
    end

endmodule

// File: rtl/retire_checker.sv
// -----------------------------------------------------------------------------
// retire_checker
// Shadow pipeline that carries expected-retirement records in lock-step with
// the core and checks each one against the register-file write port when it
// reaches the last stage.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid, in_inst,
//   in_rd, in_wr,
//   in_expect, in_pc  : record entering stage 0 (in_pc only with CHECKER_PC_EN)
//   stall, flush      : core hold / wrong-path kill of the youngest stages
//   halt_req          : core halted; stop accepting and drain
//   wb_en, wb_rd,
//   wb_data           : core register-file write port at retirement
//   mismatch          : one-cycle pulse per failed check or spurious write
//   mismatch_inst/pc  : instruction/PC of the last failure (0 for spurious)
//   check_count       : saturating count of retired records
//   error_count       : saturating count of failures
//   busy              : any stage holds a valid record
//   done              : drain finished (sticky until reset)
//
// Input protocol: in_valid qualifies in_* in the cycle it is high; there is no
// backpressure. A record is taken only when stall=0 and the state machine is
// IDLE or RUN; stall=1 freezes every stage and drops whatever is on in_*.
//
// Optional feature macro: CHECKER_PC_EN (carry PC per record, report it).
// The FSM state is visible on the internal signal 'state'.
// -----------------------------------------------------------------------------
module retire_checker
    import retire_chk_pkg::*;
#(
    parameter int XLEN        = CHK_XLEN,
    parameter int PIPE_DEPTH  = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [4:0]       in_rd,
    input  logic             in_wr,
    input  logic [XLEN-1:0]  in_expect,
    input  logic [31:0]      in_pc,
    input  logic             stall,
    input  logic             flush,
    input  logic             halt_req,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             mismatch,
    output logic [31:0]      mismatch_inst,
    output logic [31:0]      mismatch_pc,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] error_count,
    output logic             busy,
    output logic             done
);

    entry_t stg [PIPE_DEPTH];
    entry_t rec_in;
    state_t state, state_nxt;

    logic accept;
    logic check_en;
    logic retire_fire;
    logic pass;
    logic fail;
    logic spurious;

    // Halt in IDLE wins over a simultaneous record: the machine goes straight
    // to DONE and nothing further is checked.
    assign accept = in_valid &&
                    (((state == IDLE) && !halt_req) || (state == RUN));

    always_comb begin
        rec_in          = '0;
        rec_in.valid    = accept;
        rec_in.inst     = in_inst;
        rec_in.rd       = in_rd;
        rec_in.wr       = in_wr;
        rec_in.expected = in_expect;
`ifdef CHECKER_PC_EN
        rec_in.pc       = in_pc;
`endif
    end

    // ---- shadow pipeline ----------------------------------------------------
    // Flush is applied after the advance, so the record leaving stage
    // FLUSH_DEPTH-1 survives and the one entering stage 0 is dropped. It is
    // outside the stall guard because it overrides stall for its stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stg[i] <= '0;
        end else begin
            if (!stall) begin
                for (int i = PIPE_DEPTH-1; i > 0; i--) stg[i] <= stg[i-1];
                stg[0] <= rec_in;
            end
            if (flush) begin
                for (int i = 0; i < FLUSH_DEPTH; i++) stg[i].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) busy = busy | stg[i].valid;
    end

    // ---- retirement compare -------------------------------------------------
    retire_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .rd      (stg[PIPE_DEPTH-1].rd),
        .wr      (stg[PIPE_DEPTH-1].wr),
        .expected(stg[PIPE_DEPTH-1].expected),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .pass    (pass)
    );

    assign check_en    = (state != DONE);
    assign retire_fire = check_en && stg[PIPE_DEPTH-1].valid && !stall;
    assign fail        = retire_fire && !pass;
    // Any real register write with nothing retiring (including while the
    // last stage is stalled) has no record to justify it.
    assign spurious    = check_en && !retire_fire && wb_en && (wb_rd != REG_X0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch      <= 1'b0;
            mismatch_inst <= '0;
            check_count   <= '0;
            error_count   <= '0;
        end else begin
            mismatch <= fail || spurious;
            if (retire_fire && (check_count != '1)) begin
                check_count <= check_count + 1'b1;
            end
            if ((fail || spurious) && (error_count != '1)) begin
                error_count <= error_count + 1'b1;
            end
            if (fail) begin
                mismatch_inst <= stg[PIPE_DEPTH-1].inst;
            end else if (spurious) begin
                mismatch_inst <= '0;
            end
        end
    end

`ifdef CHECKER_PC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_pc <= '0;
        end else if (fail) begin
            mismatch_pc <= stg[PIPE_DEPTH-1].pc;
        end else if (spurious) begin
            mismatch_pc <= '0;
        end
    end
`else
    logic unused_pc;
    assign unused_pc   = ^in_pc;
    assign mismatch_pc = '0;
`endif

    // ---- halt / drain state machine -----------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (halt_req)                  state_nxt = DONE;
                else if (in_valid && !stall)   state_nxt = RUN;
            end
            RUN: begin
                if (halt_req)                  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!busy)                     state_nxt = DONE;
            end
            DONE:                              state_nxt = DONE;
            default:                           state_nxt = IDLE;
        endcase
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_retire_checker.sv
// -----------------------------------------------------------------------------
// tb_retire_checker
// Directed bench for retire_checker (CNT_W=4 so saturation is reachable).
// Inputs change 1 time unit after each rising edge; outputs are read there too,
// so every read reflects the state registered at the preceding edge.
// -----------------------------------------------------------------------------
module tb_retire_checker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [4:0]  in_rd;
    logic        in_wr;
    logic [31:0] in_expect;
    logic [31:0] in_pc;
    logic        stall;
    logic        flush;
    logic        halt_req;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mismatch;
    logic [31:0] mismatch_inst;
    logic [31:0] mismatch_pc;
    logic [3:0]  check_count;
    logic [3:0]  error_count;
    logic        busy;
    logic        done;

    int n_vec;
    int n_err;

    retire_checker #(
        .CNT_W(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_inst      (in_inst),
        .in_rd        (in_rd),
        .in_wr        (in_wr),
        .in_expect    (in_expect),
        .in_pc        (in_pc),
        .stall        (stall),
        .flush        (flush),
        .halt_req     (halt_req),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .mismatch     (mismatch),
        .mismatch_inst(mismatch_inst),
        .mismatch_pc  (mismatch_pc),
        .check_count  (check_count),
        .error_count  (error_count),
        .busy         (busy),
        .done         (done)
    );

    // ---- clock ---------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---- driver tasks ----------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = 1'b0;
        in_inst   = '0;
        in_rd     = '0;
        in_wr     = 1'b0;
        in_expect = '0;
        in_pc     = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        halt_req  = 1'b0;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic push(input logic [31:0] inst, input logic [4:0] rd,
                        input logic wr, input logic [31:0] exp_v,
                        input logic [31:0] pc);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_rd     = rd;
        in_wr     = wr;
        in_expect = exp_v;
        in_pc     = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd,
                      input logic [31:0] data);
        wb_en   = en;
        wb_rd   = rd;
        wb_data = data;
    endtask

    // ---- checker ---------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
        end
    endtask

    logic [31:0] exp_pc;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        clear_inputs();

        // ---- 1: reset state, then a passing lw x5 ------------------------------
        do_reset();
        check("rst_check_count", 32'(check_count), 0);
        check("rst_error_count", 32'(error_count), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_mismatch_inst", mismatch_inst, 0);
        check("rst_mismatch_pc", mismatch_pc, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        push(32'h00402283, 5'd5, 1'b1, 32'haabbccdd, 32'h80000000);
        tick();                                   // enters stage 0
        in_valid = 1'b0;
        check("lw_busy_entry", 32'(busy), 1);
        repeat (4) begin
            tick();
            check("lw_no_mismatch", 32'(mismatch), 0);
        end
        check("lw_count_pre", 32'(check_count), 0);
        wb(1'b1, 5'd5, 32'haabbccdd);
        tick();                                   // retirement registered
        wb(1'b0, 5'd0, 32'h0);
        check("lw_check_count", 32'(check_count), 1);
        check("lw_error_count", 32'(error_count), 0);
        check("lw_mismatch", 32'(mismatch), 0);
        check("lw_busy_after", 32'(busy), 0);

        // ---- 2: same record, wrong data ----------------------------------------
        do_reset();
        push(32'h00402283, 5'd5, 1'b1, 32'haabbccdd, 32'h80000010);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        wb(1'b1, 5'd5, 32'hdeadbeef);
        tick();
        wb(1'b0, 5'd0, 32'h0);
`ifdef CHECKER_PC_EN
        exp_pc = 32'h80000010;
`else
        exp_pc = 32'h0;
`endif
        check("bad_mismatch", 32'(mismatch), 1);
        check("bad_mismatch_inst", mismatch_inst, 32'h00402283);
        check("bad_mismatch_pc", mismatch_pc, exp_pc);
        check("bad_error_count", 32'(error_count), 1);
        check("bad_check_count", 32'(check_count), 1);
        tick();
        check("bad_pulse_width", 32'(mismatch), 0);
        check("bad_error_hold", 32'(error_count), 1);

        // ---- 3: nop with two stall cycles, x0 write passes ---------------------
        do_reset();
        push(32'h00000013, 5'd0, 1'b1, 32'h0, 32'h80000020);
        tick();                                   // E0: stage 0
        in_valid = 1'b0;
        tick();                                   // E1: stage 1
        stall = 1'b1;
        push(32'h00a00513, 5'd10, 1'b1, 32'ha, 32'h0);  // ignored under stall
        tick();
        tick();                                   // E2, E3: held
        in_valid = 1'b0;
        stall = 1'b0;
        repeat (3) tick();                        // E4..E6: stages 2..4
        check("nop_not_yet_retired", 32'(check_count), 0);
        check("nop_busy", 32'(busy), 1);
        wb(1'b1, 5'd0, 32'h00001234);
        tick();                                   // E7: retirement
        wb(1'b0, 5'd0, 32'h0);
        check("nop_check_count", 32'(check_count), 1);
        check("nop_error_count", 32'(error_count), 0);
        check("nop_mismatch", 32'(mismatch), 0);
        check("nop_busy_after", 32'(busy), 0);

        // ---- 4: flush kills the two younger records ----------------------------
        do_reset();
        push(32'h00100093, 5'd1, 1'b1, 32'h1, 32'h80000100);
        tick();                                   // E0
        push(32'h00200113, 5'd2, 1'b1, 32'h2, 32'h80000104);
        tick();                                   // E1
        push(32'h00300193, 5'd3, 1'b1, 32'h3, 32'h80000108);
        flush = 1'b1;
        tick();                                   // E2: flush
        in_valid = 1'b0;
        flush = 1'b0;
        tick();
        tick();                                   // E4: first record at stage 4
        wb(1'b1, 5'd1, 32'h5);                    // wrong data for x1
        tick();
        check("fl_first_mismatch", 32'(mismatch), 1);
        check("fl_first_inst", mismatch_inst, 32'h00100093);
        check("fl_first_err", 32'(error_count), 1);
        check("fl_first_chk", 32'(check_count), 1);
        wb(1'b1, 5'd2, 32'h2);                    // flushed record's write
        tick();
        check("fl_spur1_mismatch", 32'(mismatch), 1);
        check("fl_spur1_inst", mismatch_inst, 32'h0);
        check("fl_spur1_err", 32'(error_count), 2);
        wb(1'b1, 5'd3, 32'h3);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("fl_spur2_err", 32'(error_count), 3);
        check("fl_check_count", 32'(check_count), 1);
        check("fl_busy", 32'(busy), 0);

        // ---- 5: halt with three records in flight ------------------------------
        do_reset();
        push(32'h00100093, 5'd1, 1'b1, 32'h11, 32'h0);
        tick();                                   // E0
        push(32'h00200113, 5'd2, 1'b1, 32'h22, 32'h0);
        tick();                                   // E1
        push(32'h00300193, 5'd3, 1'b1, 32'h33, 32'h0);
        halt_req = 1'b1;
        tick();                                   // E2: accepted, then DRAIN
        halt_req = 1'b0;
        push(32'h00000013, 5'd0, 1'b0, 32'h0, 32'h0);  // must be ignored
        tick();                                   // E3
        in_valid = 1'b0;
        check("halt_busy_drain", 32'(busy), 1);
        check("halt_not_done", 32'(done), 0);
        tick();                                   // E4
        wb(1'b1, 5'd1, 32'h11);
        tick();                                   // E5
        wb(1'b1, 5'd2, 32'h22);
        tick();                                   // E6
        check("halt_busy_last", 32'(busy), 1);
        wb(1'b1, 5'd3, 32'h33);
        tick();                                   // E7: last retires
        wb(1'b0, 5'd0, 32'h0);
        check("halt_busy_empty", 32'(busy), 0);
        check("halt_done_early", 32'(done), 0);
        check("halt_check_count", 32'(check_count), 3);
        check("halt_error_count", 32'(error_count), 0);
        tick();                                   // E8: DONE
        check("halt_done", 32'(done), 1);
        push(32'h00700393, 5'd7, 1'b1, 32'h7, 32'h0);
        wb(1'b1, 5'd7, 32'h9);
        tick();
        tick();
        clear_inputs();
        check("done_error_frozen", 32'(error_count), 0);
        check("done_check_frozen", 32'(check_count), 3);
        check("done_no_mismatch", 32'(mismatch), 0);
        check("done_busy", 32'(busy), 0);
        check("done_sticky", 32'(done), 1);

        // ---- 6: counter saturation, async reset, IDLE -> DONE ------------------
        do_reset();
        for (int k = 0; k < 24; k++) begin
            if (k < 21) push(32'h00001000 + 32'(k), 5'd5, 1'b1, 32'(k), 32'h0);
            else        in_valid = 1'b0;
            tick();                               // no writes: every check fails
        end
        check("sat_error_count", 32'(error_count), 32'hf);
        check("sat_check_count", 32'(check_count), 32'hf);
        check("sat_mismatch", 32'(mismatch), 1);
        check("sat_mismatch_inst", mismatch_inst, 32'h00001012);
        check("sat_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;                               // between clock edges
        #1;
        check("arst_error_count", 32'(error_count), 0);
        check("arst_check_count", 32'(check_count), 0);
        check("arst_mismatch", 32'(mismatch), 0);
        check("arst_mismatch_inst", mismatch_inst, 32'h0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        clear_inputs();
        #1;
        rst = 1'b1;
        tick();
        halt_req = 1'b1;
        tick();                                   // IDLE -> DONE
        halt_req = 1'b0;
        check("idle_halt_done", 32'(done), 1);
        wb(1'b1, 5'd3, 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("idle_halt_no_err", 32'(error_count), 0);
        check("idle_halt_no_mismatch", 32'(mismatch), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/retire_checker.md
Name: retire_checker

Overview:
- Synthesisable shadow pipeline for CPU verification.
- Accepts one expected-retirement record per cycle (instruction, destination register, golden result) at fetch time.
- Carries each record through PIPE_DEPTH stages in lock-step with the core, honouring stall and flush.
- At the last stage, compares the record against the core's register-file write port; reports mismatches, counts checks and errors, and runs a halt/drain state machine.

Parameters:
- XLEN, 32, data/result width in bits.
- PIPE_DEPTH, 5, stages from record entry to retirement compare (min 2).
- FLUSH_DEPTH, 2, number of youngest stages (0..FLUSH_DEPTH-1) invalidated by flush; must be < PIPE_DEPTH.
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  record present this cycle
- in_inst  in  32  instruction word
- in_rd  in  5  destination register index
- in_wr  in  1  instruction writes rd
- in_expect  in  XLEN  golden result for rd
- in_pc  in  32  instruction PC (used only with CHECKER_PC_EN)
- stall  in  1  hold all stages
- flush  in  1  invalidate stages 0..FLUSH_DEPTH-1
- halt_req  in  1  core halt observed
- wb_en  in  1  core register-file write enable at retirement
- wb_rd  in  5  core write index
- wb_data  in  XLEN  core write data
- mismatch  out  1  one-cycle error pulse
- mismatch_inst  out  32  instruction word of the last failing record
- mismatch_pc  out  32  PC of the last failing record
- check_count  out  CNT_W  records compared
- error_count  out  CNT_W  mismatches
- busy  out  1  any stage valid
- done  out  1  drain complete, sticky

Behaviour:
- Reset (rst=0, async): all stage valids 0, FSM=IDLE, counters 0, mismatch 0, mismatch_inst/pc 0, busy 0, done 0.
- Pipeline advance:
  - stall=0: stage i+1 <= stage i; stage 0 <= {in_valid, record}.
  - stall=1: all stages hold and in_* is ignored.
- Flush:
  - Clears valid of stages 0..FLUSH_DEPTH-1 after the advance, so an in_valid record on the flush cycle is dropped.
  - flush takes priority over stall for the stages it covers.
- Retirement: occurs when the last stage is valid and stall=0. Compare is combinational that cycle; results register at the next edge (latency 1).
- Pass rules:
  - in_wr=1 and rd!=0: pass iff wb_en=1 and wb_rd==rd and wb_data==expect.
  - in_wr=0 or rd==0: pass iff wb_en=0 or wb_rd==0.
- Outcome of each retirement:
  - check_count+1.
  - On fail: error_count+1, mismatch=1 for one cycle, mismatch_inst captured.
  - Both counters saturate at all-ones.
- A write pulse (wb_en=1, wb_rd!=0) with no retiring record is a spurious write: error_count+1, mismatch=1, mismatch_inst=0.
- FSM states and transitions:
  - IDLE -> RUN on the first accepted in_valid.
  - RUN -> DRAIN on halt_req.
  - In DRAIN, in_valid is ignored; the pipeline keeps advancing and retiring.
  - DRAIN -> DONE when no stage is valid. IDLE -> DONE directly on halt_req.
  - In DONE, done=1; it is left only by reset. Compares and the spurious-write check are disabled.
- Simultaneous events: halt_req together with in_valid in RUN accepts that record, then enters DRAIN. Flush during DRAIN still applies.
- busy = OR of stage valids (combinational).

Optional Feature:
- CHECKER_PC_EN defined: each stage carries in_pc; mismatch_pc captures the failing record's PC (0 for spurious writes).
- Undefined: no PC storage; mismatch_pc tied to 0; in_pc unused.

Decomposition:
- Package retire_chk_pkg holds:
  - entry_t struct {valid, inst, rd, wr, expect, pc under macro};
  - state_t enum {IDLE, RUN, DRAIN, DONE};
  - REG_X0 constant.
- Sub-module retire_cmp: purely combinational pass/fail from the entry and the wb_* signals; instantiated once.

Test Plan:
- lw x5 (inst 0x00402283, expect 0xaabbccdd), 5 cycles no stall, wb_en=1 wb_rd=5 wb_data=0xaabbccdd at retirement -> check_count=1, error_count=0, mismatch never asserted.
- Same record with wb_data=0xdeadbeef -> mismatch pulses one cycle after retirement, mismatch_inst=0x00402283, error_count=1.
- nop (0x00000013, rd=0) followed by 2 stall cycles mid-pipe -> retirement 7 cycles after entry, check_count=1; a wb_en=1 wb_rd=0 write passes.
- Three records back-to-back, flush on cycle 2 with FLUSH_DEPTH=2 -> only the first retires, check_count=1; wb_en pulses for flushed records count as spurious errors.
- halt_req with 3 records in flight -> busy=1 until the last retires, then done=1 one cycle later; further in_valid and wb_en pulses ignored, counters frozen.
- 2^CNT_W+3 failing retirements with CNT_W=4 -> error_count saturates at 0xF; async rst mid-run clears everything immediately without waiting for clk.
